frame_sequencer: RTL and testbench

//  Sequences 74HC595 frame playback: a frame-rate divider schedules each frame.
//  Per frame, issues BYTES_PER_FRAME byte loads to the byte serializer from frame ROM, then pulses latch (STCP).

---
 rtl/frame_sequencer_pkg.sv | 17 +
 rtl/frame_sequencer_if.sv | 21 ++
 rtl/frame_tick_gen.sv | 33 +++
 rtl/frame_sequencer.sv | 101 ++++++++++
 tb/tb_frame_sequencer.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/frame_sequencer_pkg.sv
// Shared definitions for the 74HC595 frame sequencer: FSM state encoding and
// a width helper used to size index registers.
package frame_sequencer_pkg;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,
    FS_ISSUE = 2'd1,
    FS_SHIFT = 2'd2,
    FS_LATCH = 2'd3
  } fs_state_e;

  // Index width that stays at least one bit when the count is 1.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_sequencer_if.sv
// Byte handshake between the frame sequencer (master) and the byte serializer
// (slave), plus the ROM address and the 595 storage-register latch strobe.
interface frame_sequencer_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] rom_addr;
  logic              byte_valid;
  logic              byte_ready;
  logic              ser_done;
  logic              latch;

  modport master (
    output rom_addr, byte_valid, latch,
    input  byte_ready, ser_done
  );

  modport slave (
    input  rom_addr, byte_valid, latch,
    output byte_ready, ser_done
  );
endinterface

// File: rtl/frame_tick_gen.sv
// Frame-rate divider: one-cycle tick every CLK_DIV enabled cycles. The count
// freezes (is not cleared) while enable is low so pausing does not shorten a frame.
module frame_tick_gen #(
  parameter int CLK_DIV = 2500000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int            CW   = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_count;

  generate
    if (CLK_DIV < 2) begin : g_div_check
      $error("frame_tick_gen: CLK_DIV must be at least 2");
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= (r_count == LAST) ? '0 : r_count + 1'b1;
    end
  end

  assign tick = enable && (r_count == LAST);

endmodule

// File: rtl/frame_sequencer.sv
// Plays frames from ROM into a chain of 74HC595s: per frame, hands
// BYTES_PER_FRAME bytes to the serializer one at a time, then pulses STCP.
module frame_sequencer
  import frame_sequencer_pkg::*;
#(
  parameter int CLK_DIV         = 2500000,
  parameter int NUM_FRAMES      = 77,
  parameter int BYTES_PER_FRAME = 1,
  parameter int ADDR_W          = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               enable,
  input  logic                               step,
  frame_sequencer_if.master                  bus,
  output logic                               frame_start,
  output logic [clog2_min1(NUM_FRAMES)-1:0]  frame_idx,
  output logic                               busy,
  output logic                               overrun
);

  localparam int              FI_W       = clog2_min1(NUM_FRAMES);
  localparam int              BI_W       = clog2_min1(BYTES_PER_FRAME);
  localparam logic [FI_W-1:0] LAST_FRAME = FI_W'(NUM_FRAMES - 1);
  localparam logic [BI_W-1:0] LAST_BYTE  = BI_W'(BYTES_PER_FRAME - 1);

  generate
    if (longint'(NUM_FRAMES) * longint'(BYTES_PER_FRAME) > (longint'(1) << ADDR_W)) begin : g_addr_check
      $error("frame_sequencer: NUM_FRAMES*BYTES_PER_FRAME exceeds the ROM address space");
    end
  endgenerate

  fs_state_e       r_state;
  fs_state_e       w_next;
  logic            w_tick;
  logic            w_start;
  logic [BI_W-1:0] r_byte_idx;
  logic [FI_W-1:0] r_frame_idx;
  logic            r_frame_start;
  logic            r_overrun;

  frame_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .tick   (w_tick)
  );

  // Step only counts while paused; when enabled the divider alone schedules frames.
  assign w_start = w_tick || (step && !enable);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FS_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      FS_IDLE:  if (w_start) w_next = FS_ISSUE;
      FS_ISSUE: if (bus.byte_ready) w_next = FS_SHIFT;
      FS_SHIFT: if (bus.ser_done) w_next = (r_byte_idx == LAST_BYTE) ? FS_LATCH : FS_ISSUE;
      FS_LATCH: w_next = FS_IDLE;
      default:  w_next = FS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_byte_idx    <= '0;
      r_frame_idx   <= '0;
      r_frame_start <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_frame_start <= (r_state == FS_IDLE) && w_start;
      // A tick that finds the previous frame still running is lost for good.
      if (w_tick && (r_state != FS_IDLE)) r_overrun <= 1'b1;
      if ((r_state == FS_SHIFT) && bus.ser_done && (r_byte_idx != LAST_BYTE)) begin
        r_byte_idx <= r_byte_idx + 1'b1;
      end
      if (r_state == FS_LATCH) begin
        r_byte_idx  <= '0;
        r_frame_idx <= (r_frame_idx == LAST_FRAME) ? '0 : r_frame_idx + 1'b1;
      end
    end
  end

  always_comb begin
    bus.byte_valid = (r_state == FS_ISSUE);
    bus.latch      = (r_state == FS_LATCH);
    bus.rom_addr   = ADDR_W'(r_frame_idx) * ADDR_W'(BYTES_PER_FRAME) + ADDR_W'(r_byte_idx);
    busy           = (r_state != FS_IDLE);
    frame_start    = r_frame_start;
    frame_idx      = r_frame_idx;
    overrun        = r_overrun;
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed bench for frame_sequencer: a serializer model answers the byte
// handshake while a scoreboard of expected ROM addresses and latch frames is checked.
`timescale 1ns/1ps
module tb_frame_sequencer;

  localparam int CLK_DIV    = 10;
  localparam int NUM_FRAMES = 3;
  localparam int BPF        = 2;
  localparam int ADDR_W     = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       step;
  logic       frame_start;
  logic [1:0] frame_idx;
  logic       busy;
  logic       overrun;

  frame_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  frame_sequencer #(
    .CLK_DIV         (CLK_DIV),
    .NUM_FRAMES      (NUM_FRAMES),
    .BYTES_PER_FRAME (BPF),
    .ADDR_W          (ADDR_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .step        (step),
    .bus         (bus),
    .frame_start (frame_start),
    .frame_idx   (frame_idx),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int checks    = 0;
  int errors    = 0;
  int done_dly  = 8;
  bit ready_en  = 1'b1;
  int done_cnt  = 0;
  int latch_cnt = 0;
  int exp_addr_q[$];
  int exp_latch_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Serializer model and scoreboard consumer, acting 1ns after each falling edge.
  initial begin
    bus.byte_ready = 1'b0;
    bus.ser_done   = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      bus.ser_done = 1'b0;
      if (reset) begin
        done_cnt = 0;
      end else if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) bus.ser_done = 1'b1;
      end
      bus.byte_ready = ready_en;
      if (bus.byte_valid && bus.byte_ready && !reset) begin
        check("xfer_expected", int'(exp_addr_q.size() > 0), 1);
        if (exp_addr_q.size() > 0) check("xfer_rom_addr", bus.rom_addr, exp_addr_q.pop_front());
        done_cnt = done_dly;
      end
      if (bus.latch) begin
        latch_cnt++;
        check("latch_expected", int'(exp_latch_q.size() > 0), 1);
        if (exp_latch_q.size() > 0) check("latch_frame_idx", frame_idx, exp_latch_q.pop_front());
      end
    end
  end

  task automatic wait_latches(input int target, input int budget);
    int n = 0;
    while (latch_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("latch_wait", int'(latch_cnt >= target), 1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", busy, 0);
  endtask

  task automatic wait_frame_start(input int budget, output int n);
    n = 0;
    while (n < budget) begin
      @(negedge clk);
      n++;
      if (frame_start) break;
    end
  endtask

  task automatic push_frame(input int f);
    for (int b = 0; b < BPF; b++) exp_addr_q.push_back(f * BPF + b);
    exp_latch_q.push_back(f);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    int base;
    reset  = 1'b1;
    enable = 1'b0;
    step   = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_busy", busy, 0);
    check("rst_valid", bus.byte_valid, 0);
    check("rst_latch", bus.latch, 0);
    check("rst_frame_start", frame_start, 0);
    check("rst_frame_idx", frame_idx, 0);
    check("rst_rom_addr", bus.rom_addr, 0);
    check("rst_overrun", overrun, 0);

    // Free-run: first start after CLK_DIV cycles, four frames with wrap
    for (int f = 0; f < 4; f++) push_frame(f % NUM_FRAMES);
    reset  = 1'b0;
    enable = 1'b1;
    wait_frame_start(50, n);
    check("first_start_latency", n, CLK_DIV);
    check("first_valid", bus.byte_valid, 1);
    check("first_rom_addr", bus.rom_addr, 0);
    check("overrun_clear_early", overrun, 0);
    wait_latches(4, 300);
    enable = 1'b0;
    wait_idle(100);
    check("frame_idx_after_wrap", frame_idx, 1);
    check("run_addr_q_empty", exp_addr_q.size(), 0);

    // Slow serializer: ticks during SHIFT are dropped and flag overrun
    do_reset();
    done_dly = 12;
    push_frame(0);
    push_frame(1);
    reset  = 1'b0;
    enable = 1'b1;
    wait_frame_start(50, n);
    check("slow_overrun_before", overrun, 0);
    wait_latches(6, 300);
    enable = 1'b0;
    wait_idle(100);
    check("slow_overrun_set", overrun, 1);
    repeat (25) @(negedge clk);
    check("slow_overrun_sticky", overrun, 1);
    check("slow_no_restart", exp_addr_q.size(), 0);
    check("slow_frame_idx", frame_idx, 2);

    // Paused: step plays exactly one frame; step while busy is ignored
    do_reset();
    done_dly = 8;
    push_frame(0);
    reset = 1'b0;
    repeat (15) @(negedge clk);
    check("paused_no_tick", busy, 0);
    base = latch_cnt;
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    check("step_starts_frame", frame_start, 1);
    repeat (4) @(negedge clk);
    check("step_busy", busy, 1);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    wait_idle(100);
    repeat (20) @(negedge clk);
    check("step_one_latch", latch_cnt - base, 1);
    check("step_frame_idx", frame_idx, 1);
    check("step_addr_q_empty", exp_addr_q.size(), 0);
    check("step_idle_after", busy, 0);

    // Back-pressure: byte_ready low holds ISSUE; enable dropped mid-frame
    do_reset();
    ready_en = 1'b0;
    push_frame(0);
    reset  = 1'b0;
    enable = 1'b1;
    wait_frame_start(50, n);
    check("bp_start_seen", frame_start, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid_held", bus.byte_valid, 1);
      check("bp_addr_held", bus.rom_addr, 0);
    end
    base     = latch_cnt;
    ready_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_valid_dropped", bus.byte_valid, 0);
    enable = 1'b0;
    wait_idle(100);
    repeat (25) @(negedge clk);
    check("bp_frame_completed", latch_cnt - base, 1);
    check("bp_no_more_frames", busy, 0);
    check("bp_addr_q_empty", exp_addr_q.size(), 0);

    // Reset during SHIFT: outputs clear, no latch, restart at frame 0
    do_reset();
    exp_addr_q.push_back(0);
    reset  = 1'b0;
    enable = 1'b1;
    wait_frame_start(50, n);
    repeat (3) @(negedge clk);
    check("mid_in_shift", int'(busy && !bus.byte_valid), 1);
    base  = latch_cnt;
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", bus.byte_valid, 0);
    check("mid_rst_latch", bus.latch, 0);
    check("mid_rst_frame_idx", frame_idx, 0);
    check("mid_rst_rom_addr", bus.rom_addr, 0);
    @(negedge clk);
    check("mid_rst_no_latch", latch_cnt - base, 0);
    push_frame(0);
    reset = 1'b0;
    wait_frame_start(50, n);
    check("restart_latency", n, CLK_DIV);
    check("restart_addr", bus.rom_addr, 0);
    wait_latches(base + 1, 100);
    enable = 1'b0;
    wait_idle(100);
    check("restart_addr_q_empty", exp_addr_q.size(), 0);
    check("restart_latch_q_empty", exp_latch_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
